// File: rtl/traffic_pkg.sv
// Shared constants and helpers for the traffic_seq_bcd junction sequencer.
// Optional pedestrian truncation is enabled with the TRAFFIC_PED_REQ_EN macro.
package traffic_pkg;

    localparam logic [2:0] PH_AG  = 3'd0;
    localparam logic [2:0] PH_AY1 = 3'd1;
    localparam logic [2:0] PH_AL  = 3'd2;
    localparam logic [2:0] PH_AY2 = 3'd3;
    localparam logic [2:0] PH_BG  = 3'd4;
    localparam logic [2:0] PH_BY1 = 3'd5;
    localparam logic [2:0] PH_BL  = 3'd6;
    localparam logic [2:0] PH_BY2 = 3'd7;

    localparam logic [3:0] LAMP_RED = 4'h8;
    localparam logic [3:0] LAMP_YEL = 4'h4;
    localparam logic [3:0] LAMP_GRN = 4'h2;
    localparam logic [3:0] LAMP_LFT = 4'h1;
    localparam logic [3:0] LAMP_OFF = 4'h0;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_FLASH  = 2'b01;
    localparam logic [1:0] MODE_ALLRED = 2'b10;

    localparam logic [2:0] CFG_AG = 3'd0;
    localparam logic [2:0] CFG_AY = 3'd1;
    localparam logic [2:0] CFG_AL = 3'd2;
    localparam logic [2:0] CFG_BG = 3'd3;
    localparam logic [2:0] CFG_BY = 3'd4;
    localparam logic [2:0] CFG_BL = 3'd5;

    typedef enum logic [1:0] {
        EM_NORMAL = 2'd0,
        EM_FLASH  = 2'd1,
        EM_ALLRED = 2'd2
    } emode_t;

    function automatic emode_t decode_mode(input logic [1:0] m);
        case (m)
            MODE_NORMAL: decode_mode = EM_NORMAL;
            MODE_FLASH:  decode_mode = EM_FLASH;
            default:     decode_mode = EM_ALLRED;
        endcase
    endfunction

    function automatic logic [3:0] lamp_a(input logic [2:0] ph);
        if (ph[2]) begin
            lamp_a = LAMP_RED;
        end else begin
            case (ph[1:0])
                2'd0:    lamp_a = LAMP_GRN;
                2'd2:    lamp_a = LAMP_LFT;
                default: lamp_a = LAMP_YEL;
            endcase
        end
    endfunction

    function automatic logic [3:0] lamp_b(input logic [2:0] ph);
        if (!ph[2]) begin
            lamp_b = LAMP_RED;
        end else begin
            case (ph[1:0])
                2'd0:    lamp_b = LAMP_GRN;
                2'd2:    lamp_b = LAMP_LFT;
                default: lamp_b = LAMP_YEL;
            endcase
        end
    endfunction

    // Both yellow phases of an approach share one duration register.
    function automatic logic [2:0] dur_sel(input logic [2:0] ph);
        case (ph)
            PH_AG:          dur_sel = CFG_AG;
            PH_AY1, PH_AY2: dur_sel = CFG_AY;
            PH_AL:          dur_sel = CFG_AL;
            PH_BG:          dur_sel = CFG_BG;
            PH_BY1, PH_BY2: dur_sel = CFG_BY;
            default:        dur_sel = CFG_BL;
        endcase
    endfunction

    function automatic logic [31:0] to_bcd(input int unsigned v);
        int unsigned x;
        x = v;
        to_bcd = '0;
        for (int i = 0; i < 8; i++) begin
            to_bcd[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
    endfunction

endpackage

// File: rtl/bcd_down_cnt.sv
// DIGITS-digit BCD down counter with synchronous load and a count==1 flag.
// Used by traffic_seq_bcd (TRAFFIC_PED_REQ_EN has no effect here).
module bcd_down_cnt #(
    parameter int DIGITS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    input  logic                  dec_i,
    output logic [4*DIGITS-1:0]   value_o,
    output logic                  is_one_o
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] cnt_q, cnt_d, dec_val;
    logic         borrow;

    // Ripple the borrow upward: each zero digit wraps to 9 and keeps borrowing.
    always_comb begin
        borrow  = 1'b1;
        dec_val = cnt_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (cnt_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = dec_val;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o  = cnt_q;
    assign is_one_o = (cnt_q == W'(1));

endmodule

// File: rtl/traffic_seq_bcd.sv
// Eight-phase two-approach junction sequencer with BCD phase timers, night flash and all-red hold.
// Define TRAFFIC_PED_REQ_EN to add the PED_REQ green-truncation input.
module traffic_seq_bcd
    import traffic_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int DEF_AG = 40,
    parameter int DEF_AY = 5,
    parameter int DEF_AL = 15,
    parameter int DEF_BG = 30,
    parameter int DEF_BY = 5,
    parameter int DEF_BL = 15
`ifdef TRAFFIC_PED_REQ_EN
    ,parameter int PED_MIN = 10
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TICK,
    input  logic [1:0]            MODE,
    input  logic                  CFG_WE,
    input  logic [2:0]            CFG_ADDR,
    input  logic [4*DIGITS-1:0]   CFG_DATA,
`ifdef TRAFFIC_PED_REQ_EN
    input  logic                  PED_REQ,
`endif
    output logic                  CFG_ERR,
    output logic [3:0]            LAMPA,
    output logic [3:0]            LAMPB,
    output logic [4*DIGITS-1:0]   COUNT,
    output logic [2:0]            PHASE
);

    localparam int W = 4 * DIGITS;

    emode_t       mode_q;
    logic [2:0]   phase_q;
    logic [3:0]   lampa_q, lampb_q;
    logic         err_q;
    logic [W-1:0] dur_q [6];

    emode_t       req_mode;
    logic [2:0]   nxt_phase;
    logic         enter_ag, advance, leave_normal, cfg_ok, ped_cut;
    logic         cnt_load, cnt_dec, cnt_one;
    logic [W-1:0] cnt_val, cnt_value;

`ifdef TRAFFIC_PED_REQ_EN
    localparam logic [W-1:0] PED_BCD = W'(to_bcd(PED_MIN));
    logic ped_done_q;
`endif

    function automatic logic bcd_ok(input logic [W-1:0] v);
        bcd_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bcd_ok = 1'b0;
        end
    endfunction

    function automatic logic [W-1:0] load_dur(input logic [W-1:0] d);
        load_dur = (d == '0) ? W'(1) : d;
    endfunction

    always_comb begin
        req_mode     = decode_mode(MODE);
        nxt_phase    = phase_q + 3'd1;
        enter_ag     = (mode_q != EM_NORMAL) && TICK && (req_mode == EM_NORMAL);
        advance      = (mode_q == EM_NORMAL) && TICK && cnt_one && (req_mode == EM_NORMAL);
        leave_normal = (mode_q == EM_NORMAL) && TICK && cnt_one && (req_mode != EM_NORMAL);
        cfg_ok       = (CFG_ADDR <= CFG_BL) && bcd_ok(CFG_DATA);
`ifdef TRAFFIC_PED_REQ_EN
        ped_cut      = (mode_q == EM_NORMAL) && PED_REQ && !ped_done_q &&
                       ((phase_q == PH_AG) || (phase_q == PH_BG)) && (cnt_value > PED_BCD);
`else
        ped_cut      = 1'b0;
`endif
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        // Phase loads read dur_q before this edge's write, so a same-edge write is not seen.
        if (enter_ag) begin
            cnt_load = 1'b1;
            cnt_val  = load_dur(dur_q[CFG_AG]);
        end else if (advance) begin
            cnt_load = 1'b1;
            cnt_val  = load_dur(dur_q[dur_sel(nxt_phase)]);
        end else if (leave_normal) begin
            cnt_load = 1'b1;
        end else if (ped_cut) begin
`ifdef TRAFFIC_PED_REQ_EN
            cnt_load = 1'b1;
            cnt_val  = PED_BCD;
`endif
        end else if (mode_q == EM_NORMAL && TICK) begin
            cnt_dec = 1'b1;
        end
    end

    bcd_down_cnt #(.DIGITS(DIGITS)) u_cnt (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .value_o    (cnt_value),
        .is_one_o   (cnt_one)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_q         <= EM_ALLRED;
            phase_q        <= PH_AG;
            lampa_q        <= LAMP_RED;
            lampb_q        <= LAMP_RED;
            err_q          <= 1'b0;
            dur_q[CFG_AG]  <= W'(to_bcd(DEF_AG));
            dur_q[CFG_AY]  <= W'(to_bcd(DEF_AY));
            dur_q[CFG_AL]  <= W'(to_bcd(DEF_AL));
            dur_q[CFG_BG]  <= W'(to_bcd(DEF_BG));
            dur_q[CFG_BY]  <= W'(to_bcd(DEF_BY));
            dur_q[CFG_BL]  <= W'(to_bcd(DEF_BL));
`ifdef TRAFFIC_PED_REQ_EN
            ped_done_q     <= 1'b0;
`endif
        end else begin
            err_q <= CFG_WE && !cfg_ok;
            if (CFG_WE && cfg_ok) begin
                dur_q[CFG_ADDR] <= CFG_DATA;
            end
`ifdef TRAFFIC_PED_REQ_EN
            if (ped_cut) ped_done_q <= 1'b1;
            if (advance || enter_ag) ped_done_q <= 1'b0;
`endif
            case (mode_q)
                EM_NORMAL: begin
                    if (advance) begin
                        phase_q <= nxt_phase;
                        lampa_q <= lamp_a(nxt_phase);
                        lampb_q <= lamp_b(nxt_phase);
                    end else if (leave_normal) begin
                        mode_q  <= req_mode;
                        phase_q <= PH_AG;
                        lampa_q <= (req_mode == EM_FLASH) ? LAMP_YEL : LAMP_RED;
                        lampb_q <= (req_mode == EM_FLASH) ? LAMP_YEL : LAMP_RED;
                    end
                end
                default: begin
                    if (enter_ag) begin
                        mode_q  <= EM_NORMAL;
                        phase_q <= PH_AG;
                        lampa_q <= lamp_a(PH_AG);
                        lampb_q <= lamp_b(PH_AG);
                    end else if (req_mode != EM_NORMAL && req_mode != mode_q) begin
                        mode_q  <= req_mode;
                        lampa_q <= (req_mode == EM_FLASH) ? LAMP_YEL : LAMP_RED;
                        lampb_q <= (req_mode == EM_FLASH) ? LAMP_YEL : LAMP_RED;
                    end else if (mode_q == EM_FLASH && TICK) begin
                        lampa_q <= (lampa_q == LAMP_YEL) ? LAMP_OFF : LAMP_YEL;
                        lampb_q <= (lampa_q == LAMP_YEL) ? LAMP_OFF : LAMP_YEL;
                    end
                end
            endcase
        end
    end

    assign LAMPA   = lampa_q;
    assign LAMPB   = lampb_q;
    assign COUNT   = cnt_value;
    assign PHASE   = phase_q;
    assign CFG_ERR = err_q;

endmodule
